// File: rtl/data_cache.sv
//==============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-back data cache. It has 8 lines of one
//               32-bit block each. It serves CPU byte loads and stores, stalls
//               the CPU through BUSYWAIT, and on a miss runs block write-back
//               and block fetch transactions with the data memory.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_FETCH     = 2'd2;
    localparam logic [1:0] S_UPDATE    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic [31:0] w_line;
    logic        w_hit;
    logic        w_req;
    logic        w_write_hit;
    logic        w_fill;
    logic [31:0] w_merged;

    assign w_tag    = ADDRESS[7:5];
    assign w_index  = ADDRESS[4:2];
    assign w_offset = ADDRESS[1:0];
    assign w_line   = data_q[w_index];
    assign w_hit    = valid_q[w_index] && (tag_q[w_index] == w_tag);
    assign w_req    = READ | WRITE;

    // A store wins over a load when both are requested.
    assign w_write_hit = (state_q == S_IDLE) && WRITE && w_hit;
    assign w_fill      = (state_q == S_FETCH) && !MEM_BUSYWAIT;

    // The CPU stalls unless an IDLE hit can complete the request this cycle.
    assign BUSYWAIT = w_req && !((state_q == S_IDLE) && w_hit);

    // Select the load byte from the indexed line.
    always_comb begin
        READDATA = 8'h00;
        case (w_offset)
            2'd0:    READDATA = w_line[7:0];
            2'd1:    READDATA = w_line[15:8];
            2'd2:    READDATA = w_line[23:16];
            default: READDATA = w_line[31:24];
        endcase
    end

    // Build the indexed line with the store byte merged in.
    always_comb begin
        w_merged = w_line;
        w_merged[8*w_offset +: 8] = WRITEDATA;
    end

    // Choose the next controller state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    state_d = (valid_q[w_index] && dirty_q[w_index]) ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: if (!MEM_BUSYWAIT) state_d = S_FETCH;
            S_FETCH:     if (!MEM_BUSYWAIT) state_d = S_UPDATE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Drive memory requests. The bus is zero outside WRITEBACK and FETCH.
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (state_q)
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[w_index], w_index};
                MEM_WRITEDATA = w_line;
            end
            S_FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
            end
            default: ;
        endcase
    end

    // Controller state register. Reset drops any memory transaction at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Line storage. Store hits merge one byte. Fetches replace the whole block.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= 8'd0;
            dirty_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= 3'd0;
                data_q[i] <= 32'd0;
            end
        end else if (w_write_hit) begin
            data_q[w_index]  <= w_merged;
            dirty_q[w_index] <= 1'b1;
        end else if (w_fill) begin
            data_q[w_index]  <= MEM_READDATA;
            tag_q[w_index]   <= w_tag;
            valid_q[w_index] <= 1'b1;
            dirty_q[w_index] <= 1'b0;
        end
    end

endmodule

`default_nettype wire
